// File: rtl/alu_op_issuer.sv
// Purpose : initiator for the 8-bit ALU. Queues commands, drives one at a time onto
//           the ALU operand/opcode inputs, captures sum/carry and returns them on a
//           valid/ready response channel.
// Latency : push at edge T -> pop T+1 -> issue ends T+2 -> capture T+2+ALU_LAT
//           (illegal opcode: response after T+1). One command per 3+ALU_LAT cycles.
// Backpr. : cmd_ready drops when the FIFO is full or in reset; a stalled response
//           (rsp_valid && !rsp_ready) holds rsp_* and blocks further ALU issue.
// Ports   : clk/res        - clock, synchronous active-high reset
//           cmd_*          - command channel (valid/ready), operands a/b and 3-bit opcode
//           alu_a/b/oper   - registered operands and {9'b0, op} to the ALU
//           alu_sum/c_out  - ALU result inputs
//           rsp_*          - response channel (valid/ready), sum, carry, illegal-op flag
//           busy           - FSM active or FIFO non-empty
//           ops_done       - wrapping count of completed response handoffs
module alu_op_issuer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [11:0]      alu_oper,
  input  logic [7:0]       alu_sum,
  input  logic             alu_c_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = $clog2(ALU_LAT + 1);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  cmd_t           mem [DEPTH];
  cmd_t           head;
  logic [AW:0]    wr_ptr, rd_ptr;   // extra MSB distinguishes full from empty
  logic           empty, full, push, pop;
  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic           issue_load, illegal_load, capture, handoff;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full && !res;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign busy      = (state != IDLE) || !empty;

  // Storage only; occupancy is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_a, cmd_b, cmd_op};
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    issue_load   = 1'b0;
    illegal_load = 1'b0;
    capture      = 1'b0;
    handoff      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.op == 3'b111) begin
            illegal_load = 1'b1;
            state_nxt    = RESP;
          end else begin
            issue_load = 1'b1;
            state_nxt  = ISSUE;
          end
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // Counter hits zero on this edge: the ALU result is valid now.
        if (wait_cnt == WCW'(1)) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          handoff   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      state     <= IDLE;
      wait_cnt  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_oper  <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_err   <= 1'b0;
      ops_done  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);

      if (issue_load) begin
        alu_a    <= head.a;
        alu_b    <= head.b;
        alu_oper <= {9'b0, head.op};
      end

      if (state == ISSUE)     wait_cnt <= WCW'(ALU_LAT);
      else if (state == WAIT) wait_cnt <= wait_cnt - WCW'(1);

      // Illegal opcode answers immediately and leaves the ALU inputs untouched.
      if (illegal_load) begin
        rsp_sum   <= '0;
        rsp_cout  <= 1'b0;
        rsp_err   <= 1'b1;
        rsp_valid <= 1'b1;
      end

      if (capture) begin
        rsp_sum   <= alu_sum;
        rsp_cout  <= alu_c_out;
        rsp_err   <= 1'b0;
        rsp_valid <= 1'b1;
      end

      if (handoff) begin
        rsp_valid <= 1'b0;
        ops_done  <= ops_done + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             res;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a, cmd_b;
  logic [2:0]       cmd_op;
  logic [7:0]       alu_a, alu_b;
  logic [11:0]      alu_oper;
  logic [7:0]       alu_sum;
  logic             alu_c_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_sum;
  logic             rsp_cout;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  typedef struct packed {
    logic       err;
    logic       cout;
    logic [7:0] sum;
  } rsp_t;

  int   errors = 0;
  int   checks = 0;
  int   push_to = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_op_issuer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper),
    .alu_sum(alu_sum), .alu_c_out(alu_c_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .busy(busy), .ops_done(ops_done)
  );

  // ALU: one registered stage; a malformed opcode word yields a poison value.
  always @(posedge clk) begin
    logic [8:0] t;
    t = 9'h0EE;
    case (alu_oper)
      12'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
      12'd1: t = {1'b0, alu_a - alu_b};
      12'd2: t = {1'b0, alu_b - alu_a};
      12'd3: t = {1'b0, alu_a | alu_b};
      12'd4: t = {1'b0, alu_a & alu_b};
      12'd5: t = {1'b0, alu_a ^ alu_b};
      12'd6: t = {1'b0, ~(alu_a ^ alu_b)};
      default: t = 9'h1EE;
    endcase
    alu_sum   <= t[7:0];
    alu_c_out <= t[8];
  end

  // Reference: the expected response of one command, from plain integer arithmetic.
  function automatic rsp_t ref_rsp(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    rsp_t r;
    int   ia, ib, s;
    ia = int'(a);
    ib = int'(b);
    s  = 0;
    r  = '0;
    case (op)
      3'd0: s = ia + ib;
      3'd1: s = (ia - ib + 256) % 256;
      3'd2: s = (ib - ia + 256) % 256;
      3'd3: s = int'(a | b);
      3'd4: s = int'(a & b);
      3'd5: s = int'(a ^ b);
      3'd6: s = 255 - int'(a ^ b);
      default: r.err = 1'b1;
    endcase
    r.sum  = 8'(s % 256);
    r.cout = (s > 255);
    return r;
  endfunction

  // Drive one command at a negedge; returns at the negedge after it was accepted.
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (cmd_ready) exp_q.push_back(ref_rsp(a, b, op));
    else push_to++;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, snapshot it plus the ALU inputs, advance one cycle.
  task automatic get_rsp(output bit got, output rsp_t r, output logic [7:0] sa,
                         output logic [7:0] sb, output logic [11:0] so);
    int n = 0;
    got = 1'b0; r = '0; sa = '0; sb = '0; so = '0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (rsp_valid) begin
      got = 1'b1;
      r   = '{err: rsp_err, cout: rsp_cout, sum: rsp_sum};
      sa  = alu_a; sb = alu_b; so = alu_oper;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    res = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); end
    @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_oper, rsp_valid, rsp_sum, rsp_cout, rsp_err, ops_done, busy, cmd_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs a=%h b=%h op=%h v=%b s=%h c=%b e=%b n=%0d busy=%b rdy=%b want all 0",
               alu_a, alu_b, alu_oper, rsp_valid, rsp_sum, rsp_cout, rsp_err, ops_done, busy, cmd_ready);
    end
    res = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL after_reset rdy/busy/valid got=%b%b%b want=100", cmd_ready, busy, rsp_valid);
    end
  endtask

  task automatic test_single_add;
    int lat = 0;
    push_to = 0;
    rsp_ready = 1'b1;
    push_cmd(8'hFF, 8'hA1, 3'd0);
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL add_latency got=%0d want=3", lat); end
    checks++;
    if ({rsp_err, rsp_cout, rsp_sum} !== {1'b0, 1'b1, 8'hA0}) begin
      errors++; $display("FAIL add_result err=%b cout=%b sum=%h want err=0 cout=1 sum=a0", rsp_err, rsp_cout, rsp_sum);
    end
    checks++;
    if ({alu_a, alu_b, alu_oper} !== {8'hFF, 8'hA1, 12'h000}) begin
      errors++; $display("FAIL add_alu_inputs a=%h b=%h op=%h want ff a1 000", alu_a, alu_b, alu_oper);
    end
    @(negedge clk);
    checks++;
    if (ops_done !== 16'd1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_handoff ops_done=%0d valid=%b want 1 0", ops_done, rsp_valid);
    end
    checks++;
    if (push_to != 0) begin errors++; $display("FAIL add_push_timeout got=%0d want=0", push_to); end
  endtask

  task automatic test_burst;
    logic [7:0]  want_sum [5];
    logic [15:0] base;
    rsp_t        r;
    bit          got;
    bit          bad;
    logic [7:0]  sa, sb;
    logic [11:0] so;
    int          n;
    want_sum = '{8'h33, 8'h07, 8'h0D, 8'h98, 8'h20};
    push_to = 0;
    base = ops_done;
    rsp_ready = 1'b0;
    push_cmd(8'h11, 8'h22, 3'd0);       // held in RESP so the burst fills the FIFO
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL burst_blocker valid=%b want=1", rsp_valid); end
    push_cmd(8'h03, 8'h05, 3'd3);
    push_cmd(8'h04, 8'h09, 3'd5);
    push_cmd(8'h06, 8'h61, 3'd6);
    push_cmd(8'h60, 8'h21, 3'd4);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL burst_full cmd_ready=%b busy=%b want 0 1", cmd_ready, busy);
    end
    cmd_a = 8'hAA; cmd_b = 8'h55; cmd_op = 3'd0; cmd_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (cmd_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL burst_fifth_push cmd_ready went 1 while full, want 0"); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_rsp(got, r, sa, sb, so);
      checks++;
      if (!got || r !== {1'b0, 1'b0, want_sum[i]}) begin
        errors++; $display("FAIL burst_rsp%0d got=%b err=%b cout=%b sum=%h want err=0 cout=0 sum=%h",
                           i, got, r.err, r.cout, r.sum, want_sum[i]);
      end
    end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad || busy !== 1'b0) begin errors++; $display("FAIL burst_drain extra_rsp=%b busy=%b want 0 0", bad, busy); end
    checks++;
    if (ops_done !== base + 16'd5) begin errors++; $display("FAIL burst_count got=%0d want=%0d", ops_done, base + 16'd5); end
    checks++;
    if (push_to != 0) begin errors++; $display("FAIL burst_push_timeout got=%0d want=0", push_to); end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    rsp_t        r;
    bit          got, bad;
    logic [7:0]  sa, sb;
    logic [11:0] so;
    int          n = 0;
    push_to = 0;
    rsp_ready = 1'b0;
    push_cmd(8'h05, 8'h09, 3'd2);
    push_cmd(8'h01, 8'h02, 3'd0);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ({rsp_valid, rsp_err, rsp_cout, rsp_sum} !== {3'b100, 8'h04} ||
          {alu_a, alu_b, alu_oper} !== {8'h05, 8'h09, 12'h002}) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bp_hold v=%b s=%h a=%h b=%h op=%h want 1 04 05 09 002",
                         rsp_valid, rsp_sum, alu_a, alu_b, alu_oper);
    end
    rsp_ready = 1'b1;
    get_rsp(got, r, sa, sb, so);
    checks++;
    if (!got || r !== {2'b00, 8'h04}) begin errors++; $display("FAIL bp_rsp0 got=%b sum=%h want 04", got, r.sum); end
    get_rsp(got, r, sa, sb, so);
    checks++;
    if (!got || r !== {2'b00, 8'h03} || sa !== 8'h01 || sb !== 8'h02) begin
      errors++; $display("FAIL bp_rsp1 got=%b sum=%h a=%h b=%h want 03 01 02", got, r.sum, sa, sb);
    end
    checks++;
    if (push_to != 0) begin errors++; $display("FAIL bp_push_timeout got=%0d want=0", push_to); end
    exp_q.delete();
  endtask

  task automatic test_illegal;
    rsp_t        r;
    bit          got;
    logic [7:0]  sa, sb;
    logic [11:0] so;
    logic [15:0] base;
    push_to = 0;
    base = ops_done;
    rsp_ready = 1'b1;
    push_cmd(8'h10, 8'h20, 3'd0);
    push_cmd(8'h77, 8'h88, 3'd7);
    push_cmd(8'h0F, 8'hF0, 3'd5);
    get_rsp(got, r, sa, sb, so);
    checks++;
    if (!got || r !== {2'b00, 8'h30}) begin errors++; $display("FAIL ill_before got=%b r=%h want 030", got, r); end
    get_rsp(got, r, sa, sb, so);
    checks++;
    if (!got || r !== {1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL ill_rsp got=%b err=%b cout=%b sum=%h want 1 0 00", got, r.err, r.cout, r.sum);
    end
    checks++;
    if ({sa, sb, so} !== {8'h10, 8'h20, 12'h000}) begin
      errors++; $display("FAIL ill_alu_held a=%h b=%h op=%h want 10 20 000", sa, sb, so);
    end
    get_rsp(got, r, sa, sb, so);
    checks++;
    if (!got || r !== {2'b00, 8'hFF}) begin errors++; $display("FAIL ill_after got=%b r=%h want 0ff", got, r); end
    checks++;
    if (ops_done !== base + 16'd3) begin errors++; $display("FAIL ill_count got=%0d want=%0d", ops_done, base + 16'd3); end
    checks++;
    if (push_to != 0) begin errors++; $display("FAIL ill_push_timeout got=%0d want=0", push_to); end
    exp_q.delete();
  endtask

  task automatic test_reset_in_wait;
    rsp_t        r;
    bit          got, bad;
    logic [7:0]  sa, sb;
    logic [11:0] so;
    push_to = 0;
    rsp_ready = 1'b1;
    push_cmd(8'h01, 8'h01, 3'd0);
    push_cmd(8'h02, 8'h02, 3'd0);
    push_cmd(8'h03, 8'h03, 3'd0);       // first command is now in WAIT
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rw_pre busy=%b valid=%b want 1 0", busy, rsp_valid);
    end
    res = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b000 || ops_done !== '0) begin
      errors++; $display("FAIL rw_reset valid=%b rdy=%b busy=%b ops=%0d want 0 0 0 0",
                         rsp_valid, cmd_ready, busy, ops_done);
    end
    res = 1'b0;
    exp_q.delete();
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rw_discard stale activity after reset, want none"); end
    push_cmd(8'h7F, 8'h01, 3'd0);
    get_rsp(got, r, sa, sb, so);
    checks++;
    if (!got || r !== {2'b00, 8'h80}) begin errors++; $display("FAIL rw_after got=%b r=%h want 080", got, r); end
    checks++;
    if (ops_done !== 16'd1) begin errors++; $display("FAIL rw_count got=%0d want=1", ops_done); end
    checks++;
    if (push_to != 0) begin errors++; $display("FAIL rw_push_timeout got=%0d want=0", push_to); end
    exp_q.delete();
  endtask

  task automatic test_random;
    localparam int N = 40;
    int          sent = 0;
    int          rcvd = 0;
    logic [15:0] base;
    exp_q.delete();
    base = ops_done;
    fork
      begin
        for (int cyc = 0; cyc < 3000 && sent < N; cyc++) begin
          cmd_valid = ($urandom_range(0, 2) != 0);
          cmd_a  = 8'($urandom);
          cmd_b  = 8'($urandom);
          cmd_op = 3'($urandom);
          if (cmd_valid && cmd_ready) begin
            exp_q.push_back(ref_rsp(cmd_a, cmd_b, cmd_op));
            sent++;
          end
          @(negedge clk);
        end
        cmd_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 4000 && rcvd < N; cyc++) begin
          rsp_ready = ($urandom_range(0, 3) != 0);
          if (rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL rand_unexpected idx=%0d sum=%h err=%b", rcvd, rsp_sum, rsp_err);
            end else begin
              rsp_t e;
              e = exp_q.pop_front();
              if ({rsp_err, rsp_cout, rsp_sum} !== e) begin
                errors++; $display("FAIL rand_rsp%0d err=%b cout=%b sum=%h want err=%b cout=%b sum=%h",
                                   rcvd, rsp_err, rsp_cout, rsp_sum, e.err, e.cout, e.sum);
              end
            end
            rcvd++;
          end
          @(negedge clk);
        end
        rsp_ready = 1'b1;
      end
    join
    @(negedge clk);
    checks++;
    if (sent != N || rcvd != N) begin errors++; $display("FAIL rand_progress sent=%0d rcvd=%0d want %0d", sent, rcvd, N); end
    checks++;
    if (ops_done !== base + 16'(N)) begin errors++; $display("FAIL rand_count got=%0d want=%0d", ops_done, base + 16'(N)); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_burst();
    test_backpressure();
    test_illegal();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
Initiator side of the 8-bit ALU operand/opcode interface. Buffers operation commands in a small FIFO, drives one command at a time onto the ALU operand and opcode inputs, and waits the ALU's registered latency. It then captures the ALU sum/carry and returns them on a valid/ready response channel. Sits between a command source (test sequencer or control FSM) and the ALU.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
ALU_LAT, 1, clock edges from ALU sampling operands to sum/carry valid (>=1)
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  system clock, all logic on rising edge
res  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; 0 when full or res=1
cmd_a  in  8  operand a
cmd_b  in  8  operand b
cmd_op  in  3  opcode: 000 add, 001 a-b, 010 b-a, 011 or, 100 and, 101 xor, 110 xnor, 111 illegal
alu_a  out  8  registered operand a to ALU
alu_b  out  8  registered operand b to ALU
alu_oper  out  12  registered opcode to ALU, {9'b0, op}
alu_sum  in  8  ALU result
alu_c_out  in  1  ALU carry
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_sum  out  8  captured result
rsp_cout  out  1  captured carry
rsp_err  out  1  1 = illegal opcode, no ALU issue
busy  out  1  FSM not IDLE or FIFO non-empty
ops_done  out  CNT_W  count of responses handed off (valid&ready), wraps

Behaviour:
- Reset (res=1 at rising edge): FIFO emptied, FSM->IDLE, alu_a=0, alu_b=0, alu_oper=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_err=0, ops_done=0. Reset mid-operation discards the in-flight command and the pending response with no handoff.
- FIFO: push on cmd_valid&&cmd_ready. cmd_ready = !full && !res; push refused when full even if pop occurs the same cycle. Pop only by FSM in IDLE when non-empty. Pointers wrap modulo DEPTH. Push into empty FIFO with simultaneous IDLE: the entry is visible for pop the following cycle (no fall-through).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if FIFO non-empty, pop. If op!=111, load alu_a/alu_b/alu_oper and go ISSUE. If op=111, load rsp_sum=0, rsp_cout=0, rsp_err=1, rsp_valid=1, go RESP; ALU outputs unchanged.
- ISSUE: one cycle; ALU samples operands at the closing edge. Go WAIT; wait counter loaded with ALU_LAT.
- WAIT: decrement each cycle. At the edge where the counter reaches 0, capture alu_sum->rsp_sum, alu_c_out->rsp_cout, rsp_err=0, rsp_valid=1, go RESP. alu_a/alu_b/alu_oper held stable through ISSUE and WAIT.
- RESP: rsp_* held stable while rsp_valid && !rsp_ready. On rsp_valid&&rsp_ready: rsp_valid=0, ops_done+1 (wrap to 0 at max), go IDLE. No pop in the handoff cycle. A back-to-back command issues from IDLE next cycle.
- Latency, empty FIFO, legal op, rsp_ready=1: push at edge T, pop at T+1, ISSUE ends T+2, capture at T+2+ALU_LAT. rsp_valid is visible after that edge (T+3 for ALU_LAT=1). Illegal op: rsp_valid after T+1.
- Throughput: one command per 3+ALU_LAT cycles minimum. FIFO continues accepting during ISSUE/WAIT/RESP.
- Carry: only meaningful for add. Captured as presented by the ALU (0 for other ops).

Test Plan:
- Reset then idle: res=1 two cycles -> all outputs 0, cmd_ready=0 during reset, 1 after. busy=0.
- Single add: a=FF, b=A1, op=000, rsp_ready=1 -> rsp_sum=A0, rsp_cout=1, rsp_err=0, rsp_valid 3 cycles after push (ALU_LAT=1). ops_done=1.
- Burst of 4 pushed back-to-back: (03|05, op 011), (04^09, op 101), (06 xnor 61, op 110), (60&21, op 100) -> responses in order 07, 0D, 98, 20, all cout=0. cmd_ready=0 on a 5th push while full.
- Backpressure: rsp_ready=0 for 10 cycles after response to (b-a: a=05, b=09, op 010) -> rsp_sum=04 held stable, no further ALU issue. Release -> next command issues.
- Illegal op 111 between two legal ops -> rsp_err=1, rsp_sum=0, alu_* unchanged, neighbours correct. ops_done counts all three.
- Reset in WAIT with 2 queued commands -> no response, FIFO empty, ops_done=0. A new command after reset completes normally.
